// File: rtl/inst_fetch_if.sv
// inst_fetch_if: imem request/response, redirect and decode handshake
// signals of the fetch stage.
interface inst_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    output id_inst,
    output id_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    input  id_inst,
    input  id_pc,
    output id_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: RV32I fetch stage, PC + in-order imem reads + inst FIFO.
// Define INST_FETCH_PERF_EN to add redirect/bubble perf counters.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]  perf_redirect_cnt,
  output logic [31:0]  perf_bubble_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fpc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_n;
  logic [CW-1:0] drop;
  logic [AW-1:0] req_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [UW-1:0] used;
  logic [31:0]   pc_q   [FIFO_DEPTH];
  logic [31:0]   inst_q [FIFO_DEPTH];

  logic req_fire;
  logic rsp;
  logic pop;
  logic push;
  logic redir;

  assign used = UW'(inflight) + UW'(count);

  assign bus.imem_req_valid =
    !rst && (used < UW'(FIFO_DEPTH));
  assign bus.imem_req_addr = fpc;

  assign req_fire = bus.imem_req_valid
                  & bus.imem_req_ready;
  assign rsp   = bus.imem_rsp_valid;
  assign redir = bus.redirect_valid;
  assign pop   = bus.id_valid & bus.id_ready;
  assign push  = rsp & (drop == '0) & !redir;

  assign inflight_n = inflight
                    + CW'(req_fire)
                    - CW'(rsp);

  assign bus.id_valid = (count != '0);
  assign bus.id_inst  =
    bus.id_valid ? inst_q[rd_ptr] : NOP;
  assign bus.id_pc    =
    bus.id_valid ? pc_q[rd_ptr] : 32'h0;

  // Slots are allocated at request time so the pc is known
  // before the word returns; stale requests never allocate.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      req_ptr  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= inflight_n;
      if (redir) begin
        fpc     <= {bus.redirect_pc[31:2], 2'b00};
        count   <= '0;
        drop    <= inflight_n;
        req_ptr <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
      end else begin
        if (req_fire) begin
          fpc     <= fpc + 32'd4;
          req_ptr <= req_ptr + 1'b1;
        end
        if (rsp && drop != '0)
          drop <= drop - 1'b1;
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire && !redir)
      pc_q[req_ptr] <= fpc;
    if (push)
      inst_q[wr_ptr] <= bus.imem_rsp_data;
  end

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirect_cnt <= '0;
      perf_bubble_cnt   <= '0;
    end else begin
      if (redir)
        perf_redirect_cnt <= perf_redirect_cnt + 1'b1;
      if (!bus.id_valid)
        perf_bubble_cnt <= perf_bubble_cnt + 1'b1;
    end
  end
`endif

endmodule
